// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address-width computation, parameter sanity checks
// and the output-mode constants.
package fifo_pkg;

    localparam int FIFO_MODE_FWFT = 32'sd1;
    localparam int FIFO_MODE_REG  = 32'sd0;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 32'sd2) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port and one asynchronous
// read port, no reset, so it maps onto distributed RAM.
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store the accepted word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and selectable FWFT / registered-read output.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 1
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         dat_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         dat_o,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [clog2(DEPTH):0]    count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL must be below DEPTH");
    end

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_overflow;
    logic             r_underflow;
    logic [PTR_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rdata;

    // Flags come from the registered pointers only; no request input feeds them.
    assign w_count  = r_wptr - r_rptr;
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                      (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    assign w_wr_acc = wr_en_i && !w_full;
    assign w_rd_acc = rd_en_i && !w_empty;

    assign count        = w_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (w_count >= PTR_W'(AF_LEVEL));
    assign almost_empty = (w_count <= PTR_W'(AE_LEVEL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Pointer advance and sticky error capture; flush overrides both requests.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr      <= {PTR_W{1'b0}};
            r_rptr      <= {PTR_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_wptr      <= {PTR_W{1'b0}};
            r_rptr      <= {PTR_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (wr_en_i && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en_i && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc && !flush_i),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (dat_i),
        .i_raddr (r_rptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dat_o = w_empty ? {WIDTH{1'b0}} : w_rdata;
    end else begin : g_reg
        logic [WIDTH-1:0] r_dat;

        // Registered read data: captures the head word on the accepting edge.
        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) begin
                r_dat <= {WIDTH{1'b0}};
            end else if (flush_i) begin
                r_dat <= {WIDTH{1'b0}};
            end else if (w_rd_acc) begin
                r_dat <= w_rdata;
            end
        end

        assign dat_o = r_dat;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: FWFT and registered-read instances share stimulus and
// are compared against a queue-based reference model.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       wr_en_i;
    logic [3:0] dat_i;
    logic       rd_en_i;

    logic [3:0] f_dat, r_dat;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic       r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [2:0] f_count, r_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model
    logic [3:0] q[$];
    bit         m_ovf, m_unf;
    logic [3:0] m_reg;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_ni(rst_ni), .flush_i(flush_i), .wr_en_i(wr_en_i), .dat_i(dat_i),
        .rd_en_i(rd_en_i), .dat_o(f_dat), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf));

    sync_fifo #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_reg (
        .clk(clk), .rst_ni(rst_ni), .flush_i(flush_i), .wr_en_i(wr_en_i), .dat_i(dat_i),
        .rd_en_i(rd_en_i), .dat_o(r_dat), .full(r_full), .empty(r_empty),
        .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf));

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_reg = 4'h0;
    endtask

    task automatic model_step();
        int sz;
        sz = q.size();
        if (!rst_ni) begin
            model_reset();
        end else if (flush_i) begin
            model_reset();
        end else begin
            if (wr_en_i && sz == 4) m_ovf = 1'b1;
            if (rd_en_i && sz == 0) m_unf = 1'b1;
            if (rd_en_i && sz > 0) begin
                m_reg = q[0];
                void'(q.pop_front());
            end
            if (wr_en_i && sz < 4) q.push_back(dat_i);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; dat_i = 4'h0;
    endtask

    task automatic push(input logic [3:0] d);
        wr_en_i = 1'b1; rd_en_i = 1'b0; dat_i = d;
        cycle();
        idle();
    endtask

    task automatic pop();
        wr_en_i = 1'b0; rd_en_i = 1'b1;
        cycle();
        idle();
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        model_reset();
        #12;
        n_chk++;
        if ({f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_dat} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            $display("FAIL reset_fwft: count=%0d empty=%b full=%b ae=%b af=%b ovf=%b unf=%b dat=%h expected 0 1 0 1 0 0 0 0",
                     f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_dat);
            n_fail++;
        end
        n_chk++;
        if ({r_count, r_empty, r_full, r_ae, r_af, r_ovf, r_unf, r_dat} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            $display("FAIL reset_reg: count=%0d empty=%b dat=%h expected 0 1 0", r_count, r_empty, r_dat);
            n_fail++;
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fwft_basic();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'hA; exp_seq[1] = 4'h7; exp_seq[2] = 4'hB;
        push(4'hA);
        n_chk++;
        if (f_empty !== 1'b0 || f_dat !== 4'hA) begin
            $display("FAIL first_write: empty=%b dat=%h expected 0 a", f_empty, f_dat);
            n_fail++;
        end
        push(4'h7);
        push(4'hB);
        n_chk++;
        if (f_count !== 3'd3 || f_af !== 1'b1 || f_ae !== 1'b0) begin
            $display("FAIL three_writes: count=%0d af=%b ae=%b expected 3 1 0", f_count, f_af, f_ae);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (f_dat !== exp_seq[i]) begin
                $display("FAIL fwft_head%0d: got %h expected %h", i, f_dat, exp_seq[i]);
                n_fail++;
            end
            pop();
            n_chk++;
            if (r_dat !== exp_seq[i]) begin
                $display("FAIL reg_read%0d: got %h expected %h", i, r_dat, exp_seq[i]);
                n_fail++;
            end
        end
        n_chk++;
        if (f_empty !== 1'b1 || f_dat !== 4'h0 || f_unf !== 1'b0) begin
            $display("FAIL drained: empty=%b dat=%h unf=%b expected 1 0 0", f_empty, f_dat, f_unf);
            n_fail++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            push(4'(i));
            if (i == 4) begin
                n_chk++;
                if (f_full !== 1'b1 || f_count !== 3'd4 || f_ovf !== 1'b0) begin
                    $display("FAIL fill4: full=%b count=%0d ovf=%b expected 1 4 0", f_full, f_count, f_ovf);
                    n_fail++;
                end
            end
        end
        n_chk++;
        if (f_ovf !== 1'b1 || r_ovf !== 1'b1 || f_count !== 3'd4) begin
            $display("FAIL overflow: ovf=%b/%b count=%0d expected 1/1 4", f_ovf, r_ovf, f_count);
            n_fail++;
        end
        for (int i = 1; i <= 4; i++) begin
            n_chk++;
            if (f_dat !== 4'(i)) begin
                $display("FAIL drain%0d: got %h expected %h", i, f_dat, 4'(i));
                n_fail++;
            end
            pop();
        end
        n_chk++;
        if (f_empty !== 1'b1 || f_ovf !== 1'b1) begin
            $display("FAIL no_fifth: empty=%b ovf=%b expected 1 1", f_empty, f_ovf);
            n_fail++;
        end
    endtask

    task automatic test_underflow_simul();
        do_flush();
        wr_en_i = 1'b1; rd_en_i = 1'b1; dat_i = 4'hC;
        cycle();
        idle();
        n_chk++;
        if (f_unf !== 1'b1 || f_count !== 3'd1 || f_dat !== 4'hC || f_ovf !== 1'b0) begin
            $display("FAIL underflow_simul: unf=%b count=%0d dat=%h ovf=%b expected 1 1 c 0",
                     f_unf, f_count, f_dat, f_ovf);
            n_fail++;
        end
        n_chk++;
        if (r_dat !== 4'h0) begin
            $display("FAIL reg_no_read: got %h expected 0", r_dat);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        push(4'h0);
        push(4'h1);
        for (int k = 0; k < 10; k++) begin
            wr_en_i = 1'b1; rd_en_i = 1'b1; dat_i = 4'(k + 2);
            cycle();
            n_chk++;
            if (f_count !== 3'd2 || f_dat !== 4'(k + 1) || r_dat !== 4'(k) || f_ovf !== 1'b0 || f_unf !== 1'b0) begin
                $display("FAIL wrap%0d: count=%0d fdat=%h rdat=%h ovf=%b unf=%b expected 2 %h %h 0 0",
                         k, f_count, f_dat, r_dat, f_ovf, f_unf, 4'(k + 1), 4'(k));
                n_fail++;
            end
        end
        idle();
    endtask

    task automatic test_reg_mode();
        do_flush();
        push(4'h9);
        n_chk++;
        if (r_dat !== 4'h0 || r_empty !== 1'b0) begin
            $display("FAIL reg_before_read: dat=%h empty=%b expected 0 0", r_dat, r_empty);
            n_fail++;
        end
        pop();
        cycle();
        cycle();
        n_chk++;
        if (r_dat !== 4'h9 || r_empty !== 1'b1) begin
            $display("FAIL reg_hold: dat=%h empty=%b expected 9 1", r_dat, r_empty);
            n_fail++;
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push(4'(i + 3));
        pop();
        n_chk++;
        if (f_count !== 3'd3 || f_ovf !== 1'b1) begin
            $display("FAIL pre_flush: count=%0d ovf=%b expected 3 1", f_count, f_ovf);
            n_fail++;
        end
        flush_i = 1'b1; wr_en_i = 1'b1; rd_en_i = 1'b1; dat_i = 4'hE;
        cycle();
        idle();
        n_chk++;
        if (f_count !== 3'd0 || f_empty !== 1'b1 || f_ovf !== 1'b0 || f_dat !== 4'h0 || r_dat !== 4'h0) begin
            $display("FAIL flush: count=%0d empty=%b ovf=%b fdat=%h rdat=%h expected 0 1 0 0 0",
                     f_count, f_empty, f_ovf, f_dat, r_dat);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        push(4'h5);
        push(4'h6);
        pop();
        wr_en_i = 1'b1; dat_i = 4'hD;
        #2;
        rst_ni = 1'b0;
        #1;
        n_chk++;
        if ({f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_dat, r_dat} !==
            {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
            $display("FAIL async_reset: count=%0d empty=%b fdat=%h rdat=%h expected 0 1 0 0",
                     f_count, f_empty, f_dat, r_dat);
            n_fail++;
        end
        idle();
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] exp_f;
        for (int c = 0; c < 400; c++) begin
            flush_i = ($urandom_range(0, 99) < 3);
            wr_en_i = ($urandom_range(0, 99) < 55);
            rd_en_i = ($urandom_range(0, 99) < 50);
            dat_i   = 4'($urandom);
            cycle();
            exp_f = (q.size() > 0) ? q[0] : 4'h0;
            n_chk++;
            if (f_count !== 3'(q.size()) || r_count !== 3'(q.size()) ||
                f_empty !== (q.size() == 0) || f_full !== (q.size() == 4) ||
                f_af !== (q.size() >= 3) || f_ae !== (q.size() <= 1) ||
                f_ovf !== m_ovf || f_unf !== m_unf || r_ovf !== m_ovf || r_unf !== m_unf ||
                f_dat !== exp_f || r_dat !== m_reg) begin
                $display("FAIL random%0d: count=%0d/%0d empty=%b full=%b af=%b ae=%b ovf=%b unf=%b fdat=%h rdat=%h expected count=%0d ovf=%b unf=%b fdat=%h rdat=%h",
                         c, f_count, r_count, f_empty, f_full, f_af, f_ae, f_ovf, f_unf, f_dat, r_dat,
                         q.size(), m_ovf, m_unf, exp_f, m_reg);
                n_fail++;
            end
        end
        idle();
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        test_reset();
        test_fwft_basic();
        test_overflow();
        test_underflow_simul();
        test_back_to_back();
        test_reg_mode();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
